// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running pixel/line counters, registered sync,
// colour expansion to {A,B,G,R} and a sticky per-frame starvation flag.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE    = 256,
    parameter int unsigned H_FP        = 23,
    parameter int unsigned H_SYNC      = 23,
    parameter int unsigned H_BP        = 40,
    parameter int unsigned V_ACTIVE    = 240,
    parameter int unsigned V_FP        = 3,
    parameter int unsigned V_SYNC      = 3,
    parameter int unsigned V_BP        = 16,
    parameter int unsigned COLOR_DEPTH = 8,
    parameter int unsigned HS_POL      = 0,
    parameter int unsigned VS_POL      = 0,
    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW         = $clog2(H_TOTAL),
    localparam int unsigned VW         = $clog2(V_TOTAL)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COLOR_DEPTH-1:0] pix_r,
    input  logic [COLOR_DEPTH-1:0] pix_g,
    input  logic [COLOR_DEPTH-1:0] pix_b,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    output logic [HW-1:0]          hpos,
    output logic [VW-1:0]          vpos,
    output logic [31:0]            rgb,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   frame_start,
    output logic                   underflow
);

    // Sync window bounds; compared one bit wider so an end equal to the total
    // (zero back porch) does not wrap.
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic        HS_ON    = 1'(HS_POL);
    localparam logic        VS_ON    = 1'(VS_POL);
    localparam logic [31:0] RGB_BLANK = 32'hFF00_0000;

    logic          h_last_c;
    logic          v_last_c;
    logic          h_act_c;
    logic          v_act_c;
    logic          active_c;
    logic          accept_c;
    logic          starve_c;
    logic          origin_c;
    logic          hs_win_c;
    logic          vs_win_c;
    logic [7:0]    r8_c;
    logic [7:0]    g8_c;
    logic [7:0]    b8_c;
    logic [31:0]   rgb_next_c;

    // Replicate the channel's bit pattern MSB-first until 8 bits are filled.
    function automatic logic [7:0] expand(input logic [COLOR_DEPTH-1:0] c);
        logic [7:0] e;
        e = 8'h00;
        for (int i = 0; i < 8; i++) begin
            e[7-i] = c[COLOR_DEPTH-1-(i % COLOR_DEPTH)];
        end
        return e;
    endfunction

    always_comb begin
        h_last_c = (hpos == HW'(H_TOTAL - 1));
        v_last_c = (vpos == VW'(V_TOTAL - 1));
        h_act_c  = ({1'b0, hpos} < (HW+1)'(H_ACTIVE));
        v_act_c  = ({1'b0, vpos} < (VW+1)'(V_ACTIVE));
        active_c = h_act_c && v_act_c;
        accept_c = active_c && pix_valid;
        starve_c = active_c && !pix_valid;
        origin_c = (hpos == '0) && (vpos == '0);
        hs_win_c = ({1'b0, hpos} >= (HW+1)'(HS_START)) &&
                   ({1'b0, hpos} <  (HW+1)'(HS_END));
        vs_win_c = ({1'b0, vpos} >= (VW+1)'(VS_START)) &&
                   ({1'b0, vpos} <  (VW+1)'(VS_END));
    end

    assign pix_ready = active_c;

    always_comb begin
        r8_c       = expand(pix_r);
        g8_c       = expand(pix_g);
        b8_c       = expand(pix_b);
        rgb_next_c = RGB_BLANK;
        if (accept_c) begin
            rgb_next_c = {8'hFF, b8_c, g8_c, r8_c};
        end
    end

    // Position counters: line wrap advances the line counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hpos <= '0;
            vpos <= '0;
        end else begin
            if (h_last_c) begin
                hpos <= '0;
                if (v_last_c) begin
                    vpos <= '0;
                end else begin
                    vpos <= vpos + VW'(1);
                end
            end else begin
                hpos <= hpos + HW'(1);
            end
        end
    end

    // Output stage: everything here reflects the position sampled at this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb         <= RGB_BLANK;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            rgb         <= rgb_next_c;
            hsync       <= hs_win_c ? HS_ON : ~HS_ON;
            vsync       <= vs_win_c ? VS_ON : ~VS_ON;
            frame_start <= origin_c;
            // Starvation set takes priority over the start-of-frame clear.
            if (starve_c) begin
                underflow <= 1'b1;
            end else if (origin_c) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 8x6 raster, plus a 3-bit colour,
// inverted-polarity instance sharing the same clock and reset.
module tb_video_timing_gen;

    logic        clk;
    logic        reset;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;
    logic        pix_valid;
    logic        pix_ready;
    logic [2:0]  hpos;
    logic [2:0]  vpos;
    logic [31:0] rgb;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic        underflow;

    logic [2:0]  b_r;
    logic [2:0]  b_g;
    logic [2:0]  b_b;
    logic        b_valid;
    logic        b_ready;
    logic [2:0]  b_hpos;
    logic [2:0]  b_vpos;
    logic [31:0] b_rgb;
    logic        b_hsync;
    logic        b_vsync;
    logic        b_frame_start;
    logic        b_underflow;

    int          checks;
    int          errors;
    int          h;
    int          v;
    logic        uf_exp;
    logic        act;
    int          fs_cnt;
    int          rdy_cnt;
    logic [31:0] line1 [8];
    logic [31:0] line1_exp [8];

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .COLOR_DEPTH(8), .HS_POL(0), .VS_POL(0)
    ) dut (
        .clk(clk), .reset(reset),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .hpos(hpos), .vpos(vpos), .rgb(rgb),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
        .underflow(underflow)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .COLOR_DEPTH(3), .HS_POL(1), .VS_POL(1)
    ) dut_b (
        .clk(clk), .reset(reset),
        .pix_r(b_r), .pix_g(b_g), .pix_b(b_b), .pix_valid(b_valid),
        .pix_ready(b_ready), .hpos(b_hpos), .vpos(b_vpos), .rgb(b_rgb),
        .hsync(b_hsync), .vsync(b_vsync), .frame_start(b_frame_start),
        .underflow(b_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (h=%0d v=%0d)", tag, obs, exp, h, v);
        end
    endtask

    // One pixel clock at model position (h,v); drop=1 withholds pix_valid.
    task automatic step(input logic drop);
        logic        hs_exp;
        logic        vs_exp;
        logic [31:0] rgb_exp;
        act       = (h < 4) && (v < 3);
        pix_r     = 8'(h);
        pix_g     = 8'(v);
        pix_b     = 8'h5A;
        pix_valid = !drop;
        #1;
        chk("hpos", 32'(hpos), 32'(h));
        chk("vpos", 32'(vpos), 32'(v));
        chk("pix_ready", 32'(pix_ready), 32'(act));
        if (pix_ready) rdy_cnt++;
        @(posedge clk);
        #1;
        hs_exp  = !((h == 5) || (h == 6));
        vs_exp  = !(v == 4);
        rgb_exp = (act && !drop) ? {8'hFF, 8'h5A, 8'(v), 8'(h)} : 32'hFF00_0000;
        if (act && drop) uf_exp = 1'b1;
        else if (h == 0 && v == 0) uf_exp = 1'b0;
        chk("rgb", rgb, rgb_exp);
        chk("hsync", 32'(hsync), 32'(hs_exp));
        chk("vsync", 32'(vsync), 32'(vs_exp));
        chk("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));
        chk("underflow", 32'(underflow), 32'(uf_exp));
        chk("b_rgb", b_rgb, act ? 32'hFF00_FFB6 : 32'hFF00_0000);
        chk("b_hsync", 32'(b_hsync), 32'(!hs_exp));
        chk("b_vsync", 32'(b_vsync), 32'(!vs_exp));
        if (frame_start) fs_cnt++;
        if (v == 1) line1[h] = rgb;
        if (h == 7) begin
            h = 0;
            v = (v == 5) ? 0 : v + 1;
        end else begin
            h = h + 1;
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_hpos"}, 32'(hpos), 32'd0);
        chk({tag, "_vpos"}, 32'(vpos), 32'd0);
        chk({tag, "_rgb"}, rgb, 32'hFF00_0000);
        chk({tag, "_hsync"}, 32'(hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(vsync), 32'd1);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
        chk({tag, "_uf"}, 32'(underflow), 32'd0);
        chk({tag, "_b_hsync"}, 32'(b_hsync), 32'd0);
        chk({tag, "_b_vsync"}, 32'(b_vsync), 32'd0);
        chk({tag, "_b_rgb"}, b_rgb, 32'hFF00_0000);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        h         = 0;
        v         = 0;
        uf_exp    = 1'b0;
        fs_cnt    = 0;
        rdy_cnt   = 0;
        reset     = 1'b0;
        pix_r     = 8'h00;
        pix_g     = 8'h00;
        pix_b     = 8'h00;
        pix_valid = 1'b0;
        b_r       = 3'b101;
        b_g       = 3'b111;
        b_b       = 3'b000;
        b_valid   = 1'b1;
        line1_exp[0] = 32'hFF5A_0100;
        line1_exp[1] = 32'hFF5A_0101;
        line1_exp[2] = 32'hFF5A_0102;
        line1_exp[3] = 32'hFF5A_0103;
        line1_exp[4] = 32'hFF00_0000;
        line1_exp[5] = 32'hFF00_0000;
        line1_exp[6] = 32'hFF00_0000;
        line1_exp[7] = 32'hFF00_0000;

        // Held in reset across a few edges.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("por");
        chk("por_pix_ready", 32'(pix_ready), 32'd1);
        #2 reset = 1'b1;

        // Frame 1: free run with data.
        for (int i = 0; i < 48; i++) step(1'b0);
        chk("frame1_fs_count", 32'(fs_cnt), 32'd1);
        chk("frame1_ready_count", 32'(rdy_cnt), 32'd12);
        for (int i = 0; i < 8; i++) chk($sformatf("line1_%0d", i), line1[i], line1_exp[i]);

        // Frame 2: starve at (2,1) only.
        fs_cnt  = 0;
        rdy_cnt = 0;
        for (int i = 0; i < 48; i++) step((h == 2) && (v == 1));
        chk("frame2_fs_count", 32'(fs_cnt), 32'd1);
        chk("frame2_ready_count", 32'(rdy_cnt), 32'd12);
        chk("uf_sticky_end", 32'(underflow), 32'd1);

        // Frame 3: underflow clears with frame_start, then run up to (3,2).
        step(1'b0);
        chk("uf_cleared", 32'(underflow), 32'd0);
        chk("fs_with_clear", 32'(frame_start), 32'd1);
        for (int i = 1; i < 19; i++) step(1'b0);
        chk("pre_reset_h", 32'(h), 32'd3);
        chk("pre_reset_rgb", rgb, 32'hFF5A_0202);

        // Mid-frame reset: immediate, then held for 3 edges.
        #2 reset = 1'b0;
        #1;
        chk_reset_values("mid");
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_reset_values("hold");
        end
        #2 reset = 1'b1;
        h      = 0;
        v      = 0;
        uf_exp = 1'b0;
        step(1'b0);
        chk("restart_fs", 32'(frame_start), 32'd1);
        chk("restart_pix00", rgb, 32'hFF5A_0000);
        for (int i = 0; i < 10; i++) step(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
